// File: rtl/power_converter_ramp.sv
// power_converter_ramp: gain stage (pass / boost x2 / buck /2) with saturation,
// slew-limited regulated output and a period-synchronous PWM gate drive.
// Optional over-voltage protection is built when POWER_CONVERTER_OVP_EN is defined.
module power_converter_ramp #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned SLEW_STEP = 4,
    parameter int unsigned OVP_LIMIT = (1 << WIDTH) - 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] ui_in,
    input  logic [1:0]       mode,
    input  logic             enable,
    output logic [WIDTH-1:0] uo_out,
    output logic             pwm_out,
    output logic             sat,
    output logic             ramp_done,
    output logic             fault
);

    localparam logic [WIDTH-1:0] SLEW = WIDTH'(SLEW_STEP);

`ifdef POWER_CONVERTER_OVP_EN
    localparam logic [WIDTH-1:0] OVP_W = WIDTH'(OVP_LIMIT);
    typedef enum logic [1:0] {IDLE, RAMP, TRACK, FAULT} state_t;
`else
    typedef enum logic [1:0] {IDLE, RAMP, TRACK} state_t;
`endif

    state_t           state_q, state_d;
    logic [WIDTH-1:0] in_q;
    logic [1:0]       mode_q;
    logic             en_q;
    logic [WIDTH-1:0] uo_q, uo_d;
    logic             done_q, done_d;
    logic             sat_q, sat_d;
    logic [WIDTH-1:0] cnt_q, duty_q;

    logic [WIDTH:0]   tgt_wide;
    logic [WIDTH-1:0] target;
    logic [WIDTH-1:0] diff, step, moved;
    logic             up, arrive, run, do_move;

    // Input sampling register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            in_q   <= '0;
            mode_q <= 2'b00;
            en_q   <= 1'b0;
        end else begin
            in_q   <= ui_in;
            mode_q <= mode;
            en_q   <= enable;
        end
    end

    // Gain selection with boost clamp, plus the bounded move toward target
    always_comb begin
        case (mode_q)
            2'b01:   tgt_wide = {1'b0, in_q};
            2'b10:   tgt_wide = {in_q, 1'b0};
            2'b11:   tgt_wide = {2'b00, in_q[WIDTH-1:1]};
            default: tgt_wide = '0;
        endcase
        sat_d  = (mode_q == 2'b10) && tgt_wide[WIDTH];
        target = sat_d ? '1 : tgt_wide[WIDTH-1:0];
        up     = target > uo_q;
        diff   = up ? (target - uo_q) : (uo_q - target);
        step   = (diff > SLEW) ? SLEW : diff;
        moved  = up ? (uo_q + step) : (uo_q - step);
        arrive = (moved == target);
        run    = en_q && (mode_q != 2'b00);
    end

`ifdef POWER_CONVERTER_OVP_EN
    logic fault_q, fault_d;
`endif

    // Next-state and regulated-output logic
    always_comb begin
        state_d = state_q;
        uo_d    = uo_q;
        done_d  = done_q;
        do_move = 1'b0;
`ifdef POWER_CONVERTER_OVP_EN
        fault_d = fault_q;
`endif
        case (state_q)
            IDLE: begin
                uo_d    = '0;
                done_d  = 1'b0;
                do_move = run;
            end
            RAMP, TRACK: do_move = 1'b1;
`ifdef POWER_CONVERTER_OVP_EN
            FAULT: begin
                uo_d    = '0;
                done_d  = 1'b0;
                fault_d = 1'b1;
            end
`endif
            default: state_d = IDLE;
        endcase
        // IDLE, RAMP and TRACK share one move: TRACK with an unchanged target
        // yields a zero step and stays put.
        if (do_move) begin
            uo_d    = moved;
            done_d  = arrive;
            state_d = arrive ? TRACK : RAMP;
`ifdef POWER_CONVERTER_OVP_EN
            if (moved > OVP_W) begin
                uo_d    = '0;
                done_d  = 1'b0;
                fault_d = 1'b1;
                state_d = FAULT;
            end
`endif
        end
        if (!run) begin
            state_d = IDLE;
            uo_d    = '0;
            done_d  = 1'b0;
`ifdef POWER_CONVERTER_OVP_EN
            fault_d = 1'b0;
`endif
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            uo_q    <= '0;
            done_q  <= 1'b0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            uo_q    <= uo_d;
            done_q  <= done_d;
            sat_q   <= sat_d;
        end
    end

`ifdef POWER_CONVERTER_OVP_EN
    // Over-voltage latch
    always_ff @(posedge clk) begin
        if (!rst_n) fault_q <= 1'b0;
        else        fault_q <= fault_d;
    end
    assign fault   = fault_q;
    assign pwm_out = (cnt_q < duty_q) && (state_q != FAULT);
`else
    assign fault   = 1'b0;
    assign pwm_out = (cnt_q < duty_q);
`endif

    // PWM counter; duty reloads only at period end so a period never glitches
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            duty_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == '1) duty_q <= uo_q;
        end
    end

    assign uo_out    = uo_q;
    assign sat       = sat_q;
    assign ramp_done = done_q;

endmodule

// File: tb/tb_power_converter_ramp.sv
// Directed bench for power_converter_ramp (WIDTH=8, SLEW_STEP=4, OVP_LIMIT=240).
// The OVP scenario is compiled in when POWER_CONVERTER_OVP_EN is defined.
module tb_power_converter_ramp;

    logic       clk;
    logic       rst_n;
    logic [7:0] ui_in;
    logic [1:0] mode;
    logic       enable;
    logic [7:0] uo_out;
    logic       pwm_out;
    logic       sat;
    logic       ramp_done;
    logic       fault;

    int cmp;
    int err;

    power_converter_ramp #(.WIDTH(8), .SLEW_STEP(4), .OVP_LIMIT(240)) dut (
        .clk(clk), .rst_n(rst_n), .ui_in(ui_in), .mode(mode), .enable(enable),
        .uo_out(uo_out), .pwm_out(pwm_out), .sat(sat), .ramp_done(ramp_done),
        .fault(fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int highs;
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ui_in = 8'($urandom); mode = 2'($urandom); enable = 1'($urandom);
            tick();
        end
        cmp++;
        if ({uo_out, sat, ramp_done, fault, pwm_out} !== 12'h000) begin
            err++;
            $display("FAIL reset_outputs got uo=%0d sat=%b done=%b fault=%b pwm=%b want all 0",
                     uo_out, sat, ramp_done, fault, pwm_out);
        end
        highs = 0;
        for (int i = 0; i < 256; i++) begin
            ui_in = 8'($urandom); mode = 2'($urandom); enable = 1'($urandom);
            tick();
            if (pwm_out) highs++;
        end
        cmp++;
        if (highs !== 0) begin
            err++;
            $display("FAIL reset_pwm high cycles got %0d want 0", highs);
        end
        ui_in = 8'd0; mode = 2'b00; enable = 1'b0; rst_n = 1'b1;
        tick();
    endtask

    task automatic test_boost_softstart();
        int exp_uo;
        ui_in = 8'd100; mode = 2'b10; enable = 1'b1;
        tick();
        cmp++;
        if (uo_out !== 8'd0) begin
            err++;
            $display("FAIL boost_latency uo_out got %0d want 0", uo_out);
        end
        for (int e = 2; e <= 51; e++) begin
            tick();
            exp_uo = 4 * (e - 1);
            cmp++;
            if ({uo_out, ramp_done, sat} !== {8'(exp_uo), (e == 51), 1'b0}) begin
                err++;
                $display("FAIL boost_ramp edge %0d got uo=%0d done=%b sat=%b want uo=%0d done=%b sat=0",
                         e, uo_out, ramp_done, sat, exp_uo, (e == 51));
            end
        end
        tick();
        cmp++;
        if ({uo_out, ramp_done} !== {8'd200, 1'b1}) begin
            err++;
            $display("FAIL boost_hold got uo=%0d done=%b want uo=200 done=1", uo_out, ramp_done);
        end
    endtask

    task automatic test_sat_buck();
        int exp_uo;
        ui_in = 8'd200;
        tick();
        cmp++;
        if ({uo_out, sat} !== {8'd200, 1'b0}) begin
            err++;
            $display("FAIL sat_latency got uo=%0d sat=%b want uo=200 sat=0", uo_out, sat);
        end
        for (int e = 2; e <= 15; e++) begin
            tick();
            exp_uo = (200 + 4 * (e - 1) > 255) ? 255 : 200 + 4 * (e - 1);
            cmp++;
            if ({uo_out, ramp_done, sat} !== {8'(exp_uo), (e == 15), 1'b1}) begin
                err++;
                $display("FAIL sat_ramp edge %0d got uo=%0d done=%b sat=%b want uo=%0d done=%b sat=1",
                         e, uo_out, ramp_done, sat, exp_uo, (e == 15));
            end
        end
        mode = 2'b11; ui_in = 8'd201;
        tick();
        cmp++;
        if ({uo_out, sat, ramp_done} !== {8'd255, 1'b1, 1'b1}) begin
            err++;
            $display("FAIL buck_latency got uo=%0d sat=%b done=%b want uo=255 sat=1 done=1",
                     uo_out, sat, ramp_done);
        end
        for (int e = 2; e <= 40; e++) begin
            tick();
            exp_uo = (255 - 4 * (e - 1) < 100) ? 100 : 255 - 4 * (e - 1);
            cmp++;
            if ({uo_out, ramp_done, sat} !== {8'(exp_uo), (e == 40), 1'b0}) begin
                err++;
                $display("FAIL buck_ramp edge %0d got uo=%0d done=%b sat=%b want uo=%0d done=%b sat=0",
                         e, uo_out, ramp_done, sat, exp_uo, (e == 40));
            end
        end
    endtask

    task automatic test_pwm();
        int  highs;
        int  last;
        bit  found;
        logic prev;
        mode = 2'b01; ui_in = 8'd64;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (ramp_done && uo_out == 8'd64) break;
        end
        cmp++;
        if ({uo_out, ramp_done} !== {8'd64, 1'b1}) begin
            err++;
            $display("FAIL pwm_settle got uo=%0d done=%b want uo=64 done=1", uo_out, ramp_done);
        end
        repeat (256) tick();
        found = 1'b0;
        prev  = pwm_out;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (!prev && pwm_out) begin found = 1'b1; break; end
            prev = pwm_out;
        end
        cmp++;
        if (found !== 1'b1) begin
            err++;
            $display("FAIL pwm_rise got no rising edge within 300 cycles want one");
        end
        highs = 1; last = 0;
        for (int i = 1; i < 256; i++) begin
            tick();
            if (pwm_out) begin highs++; last = i; end
        end
        cmp++;
        if (highs !== 64 || last !== 63) begin
            err++;
            $display("FAIL pwm_duty64 got high=%0d last_high=%0d want high=64 last_high=63", highs, last);
        end
        tick();
        highs = pwm_out ? 1 : 0;
        for (int i = 1; i < 256; i++) begin
            if (i == 10) ui_in = 8'd200;
            tick();
            if (pwm_out) highs++;
        end
        cmp++;
        if (highs !== 64) begin
            err++;
            $display("FAIL pwm_midperiod got high=%0d want 64", highs);
        end
    endtask

    task automatic test_disable_midramp();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1; ui_in = 8'd100; mode = 2'b10; enable = 1'b1;
        repeat (11) tick();
        cmp++;
        if (uo_out !== 8'd40) begin
            err++;
            $display("FAIL dis_reach40 uo_out got %0d want 40", uo_out);
        end
        enable = 1'b0;
        tick();
        cmp++;
        if (uo_out !== 8'd44) begin
            err++;
            $display("FAIL dis_sample uo_out got %0d want 44", uo_out);
        end
        tick();
        cmp++;
        if ({uo_out, ramp_done} !== {8'd0, 1'b0}) begin
            err++;
            $display("FAIL dis_idle got uo=%0d done=%b want uo=0 done=0", uo_out, ramp_done);
        end
    endtask

    task automatic test_reset_midramp();
        enable = 1'b1;
        repeat (11) tick();
        cmp++;
        if (uo_out !== 8'd40) begin
            err++;
            $display("FAIL rst_reach40 uo_out got %0d want 40", uo_out);
        end
        rst_n = 1'b0;
        tick();
        cmp++;
        if ({uo_out, sat, ramp_done, pwm_out} !== 11'h000) begin
            err++;
            $display("FAIL rst_midramp got uo=%0d sat=%b done=%b pwm=%b want all 0",
                     uo_out, sat, ramp_done, pwm_out);
        end
        rst_n = 1'b1;
    endtask

`ifdef POWER_CONVERTER_OVP_EN
    task automatic test_ovp();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1; ui_in = 8'd125; mode = 2'b10; enable = 1'b1;
        repeat (61) tick();
        cmp++;
        if ({uo_out, fault} !== {8'd240, 1'b0}) begin
            err++;
            $display("FAIL ovp_limit got uo=%0d fault=%b want uo=240 fault=0", uo_out, fault);
        end
        tick();
        cmp++;
        if ({uo_out, fault, ramp_done} !== {8'd0, 1'b1, 1'b0}) begin
            err++;
            $display("FAIL ovp_trip got uo=%0d fault=%b done=%b want uo=0 fault=1 done=0",
                     uo_out, fault, ramp_done);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            cmp++;
            if ({uo_out, fault, pwm_out} !== {8'd0, 1'b1, 1'b0}) begin
                err++;
                $display("FAIL ovp_hold got uo=%0d fault=%b pwm=%b want uo=0 fault=1 pwm=0",
                         uo_out, fault, pwm_out);
            end
        end
        enable = 1'b0;
        tick();
        cmp++;
        if (fault !== 1'b1) begin
            err++;
            $display("FAIL ovp_sample fault got %b want 1", fault);
        end
        tick();
        cmp++;
        if ({uo_out, fault} !== {8'd0, 1'b0}) begin
            err++;
            $display("FAIL ovp_clear got uo=%0d fault=%b want uo=0 fault=0", uo_out, fault);
        end
    endtask
`endif

    initial begin
        cmp = 0; err = 0;
        rst_n = 1'b0; ui_in = 8'd0; mode = 2'b00; enable = 1'b0;
        test_reset();
        test_boost_softstart();
        test_sat_buck();
        test_pwm();
        test_disable_midramp();
        test_reset_midramp();
`ifdef POWER_CONVERTER_OVP_EN
        test_ovp();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
        $finish;
    end

endmodule
